// File: rtl/mult_div_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - op encodings for the 3-bit op port
//   - FSM state enumeration
//   - helpers that classify an op and pick its latency
package mult_div_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    // Only 010/011 are divides; every other encoding uses the multiplier.
    function automatic logic is_div_op(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

    function automatic int op_latency(input logic [2:0] op,
                                      input int mult_lat,
                                      input int div_lat);
        return is_div_op(op) ? div_lat : mult_lat;
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational datapath of the multiply/divide unit.
// Ports:
//   op_i   - latched operation code
//   a_i    - latched rs (multiplicand / dividend)
//   b_i    - latched rt (multiplier / divisor)
//   acc_i  - {HI,LO} held at launch (accumulator for madd/msub)
//   res_o  - 2*WIDTH result to be written as {HI,LO}
//   wr_o   - low when the result must not be written (divide by zero)
module md_core
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] res_o,
    output logic               wr_o
);

    logic               sgn;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        // op[0] clear selects the signed flavour of every operation.
        sgn   = ~op_i[0];

        // The low 2*WIDTH bits of the product of sign-extended operands
        // are the exact signed product, so one multiplier serves both.
        a_ext = sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        b_ext = sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
        prod  = a_ext * b_ext;

        // Divide on magnitudes, then restore signs. The magnitude of the
        // most negative value is still representable as unsigned, which
        // makes -2^(W-1) / -1 come out as -2^(W-1) remainder 0.
        a_neg  = sgn & a_i[WIDTH-1];
        b_neg  = sgn & b_i[WIDTH-1];
        b_zero = (b_i == '0);
        a_mag  = a_neg ? -a_i : a_i;
        b_mag  = b_neg ? -b_i : b_i;
        q_mag  = b_zero ? '0 : (a_mag / b_mag);
        r_mag  = b_zero ? '0 : (a_mag % b_mag);
        quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;

        wr_o   = ~(is_div_op(op_i) & b_zero);

        case (op_i)
            OP_MULT, OP_MULTU: res_o = prod;
            OP_MADD, OP_MADDU: res_o = acc_i + prod;
            OP_MSUB, OP_MSUBU: res_o = acc_i - prod;
            OP_DIV,  OP_DIVU:  res_o = {rem, quo};
            default:           res_o = acc_i;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit with fixed-latency operations.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start, op     - one-cycle launch request and operation select
//   d1, d2        - rs / rt operands
//   we, hilo_sel  - direct write of d1 into HI (0) or LO (1) when idle
//   flush         - abort the operation in flight
//   busy          - operation in flight
//   done          - one-cycle pulse when HI/LO take a result
//   hi, lo        - registered HI and LO
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             we,
    input  logic             hilo_sel,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               launch;
    logic [2*WIDTH-1:0] core_res;
    logic               core_wr;

    md_core #(.WIDTH(WIDTH)) u_core (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .acc_i ({hi_q, lo_q}),
        .res_o (core_res),
        .wr_o  (core_wr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        launch  = 1'b0;

        case (state_q)
            IDLE: begin
                // start beats we; flush only matters here by blocking start.
                if (start && !flush) begin
                    launch  = 1'b1;
                    cnt_d   = CNT_W'(op_latency(op, MULT_LAT, DIV_LAT));
                    state_d = is_div_op(op) ? DIV : MUL;
                end else if (we) begin
                    if (hilo_sel) lo_d = d1;
                    else          hi_d = d1;
                end
            end
            MUL, DIV: begin
                // Abort wins even on the final busy cycle.
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (core_wr) begin
                        hi_d = core_res[2*WIDTH-1:WIDTH];
                        lo_d = core_res[WIDTH-1:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Operand capture is pure data and only meaningful after a launch.
    always_ff @(posedge clk) begin
        if (launch) begin
            op_q <= op;
            a_q  <= d1;
            b_q  <= d2;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] d1 = '0;
    logic [W-1:0] d2 = '0;
    logic         we = 1'b0;
    logic         hilo_sel = 1'b0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .d1       (d1),
        .d2       (d2),
        .we       (we),
        .hilo_sel (hilo_sel),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of the architectural result.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sbv;
        logic [63:0] sp, up;
        int          q, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        sp  = 64'(sa * sbv);
        up  = {32'd0, a} * {32'd0, b};
        case (o)
            3'b000: return sp;
            3'b001: return up;
            3'b100: return acc + sp;
            3'b101: return acc + up;
            3'b110: return acc - sp;
            3'b111: return acc - up;
            3'b010: begin
                if (b == 32'd0) return acc;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard consumer: every done must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) check_eq("unexpected_done", {63'd0, done}, 64'd0);
            else                check_eq("result", {hi, lo}, sb.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Count busy cycles after a launch, optionally poking start+we mid-flight.
    task automatic finish_op(input string tag, input int lat, input logic [63:0] exp, input bit poke);
        int n;
        n = 0;
        while (busy && n < 64) begin
            n++;
            if (poke && n == 2) begin
                start = 1'b1; we = 1'b1; hilo_sel = 1'b0;
                op = 3'b011; d1 = 32'hDEAD_BEEF; d2 = 32'd3;
            end else begin
                start = 1'b0; we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; we = 1'b0;
        check_eq({tag, "_busy_len"}, 64'(n), 64'(lat));
        check_eq({tag, "_done"}, {63'd0, done}, 64'd1);
        {m_hi, m_lo} = exp;
        @(negedge clk);
        check_eq({tag, "_done_once"}, {63'd0, done}, 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit poke, input bit we_too);
        logic [63:0] exp;
        exp = ref_op(o, a, b, {m_hi, m_lo});
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b1; op = o; d1 = a; d2 = b;
        if (we_too) begin we = 1'b1; hilo_sel = 1'b1; end
        @(negedge clk);
        start = 1'b0; we = 1'b0;
        finish_op(tag, (o[2:1] == 2'b01) ? DL : ML, exp, poke);
    endtask

    task automatic do_mt(input string tag, input bit sel, input logic [31:0] val);
        @(negedge clk);
        we = 1'b1; hilo_sel = sel; d1 = val;
        @(negedge clk);
        we = 1'b0;
        if (sel) m_lo = val; else m_hi = val;
        check_eq(tag, {32'd0, sel ? lo : hi}, {32'd0, val});
        check_eq({tag, "_no_done"}, {63'd0, done}, 64'd0);
    endtask

    task automatic do_flush(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int at);
        @(negedge clk);
        start = 1'b1; op = o; d1 = a; d2 = b;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < at; k++) @(negedge clk);
        check_eq({tag, "_busy_before"}, {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_no_done"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
        repeat (DL + 2) @(negedge clk);
        check_eq({tag, "_hilo_later"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        logic [63:0] exp;

        repeat (3) @(negedge clk);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);

        // Release reset and launch on the very next edge.
        exp = ref_op(3'b000, 32'hFFFF_FFFD, 32'd5, {m_hi, m_lo});
        sb.push_back(exp);
        rst = 1'b0;
        start = 1'b1; op = 3'b000; d1 = 32'hFFFF_FFFD; d2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check_eq("first_start_busy", {63'd0, busy}, 64'd1);
        finish_op("mult_neg3x5", ML, exp, 1'b0);
        check_eq("mult_neg3x5_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        do_op("divu_100_7", 3'b011, 32'd100, 32'd7, 1'b0, 1'b0);
        check_eq("divu_val", {hi, lo}, {32'd2, 32'd14});
        do_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check_eq("div_m7_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        do_mt("mtlo", 1'b1, 32'hFFFF_FFFF);
        do_mt("mthi", 1'b0, 32'd0);
        do_op("madd_1x1", 3'b100, 32'd1, 32'd1, 1'b0, 1'b0);
        check_eq("madd_val", {hi, lo}, {32'd1, 32'd0});
        do_op("msub_1x1", 3'b110, 32'd1, 32'd1, 1'b0, 1'b0);
        check_eq("msub_val", {hi, lo}, {32'd0, 32'hFFFF_FFFF});

        do_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_eq("div_ovf_val", {hi, lo}, {32'd0, 32'h8000_0000});
        do_mt("preset_hi", 1'b0, 32'h11);
        do_mt("preset_lo", 1'b1, 32'h22);
        do_op("div_by0", 3'b010, 32'd1234, 32'd0, 1'b0, 1'b0);
        check_eq("div_by0_val", {hi, lo}, {32'h11, 32'h22});

        do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("maddu", 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        do_op("msubu", 3'b111, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            do_op("rand", 3'(i), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 + $urandom_range(1, 9) : $urandom, 1'b0, 1'b0);

        do_flush("flush_div", 3'b010, 32'd500, 32'd7, 3);
        do_flush("flush_mul_last", 3'b000, 32'd9, 32'd9, ML);

        do_op("poke_busy", 3'b001, 32'd6, 32'd7, 1'b1, 1'b0);
        do_op("start_we_idle", 3'b000, 32'd3, 32'd11, 1'b0, 1'b1);

        // flush together with start in IDLE: nothing launches.
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 3'b000; d1 = 32'd3; d2 = 32'd4;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check_eq("flush_start_busy", {63'd0, busy}, 64'd0);
        repeat (ML + 2) @(negedge clk);
        check_eq("flush_start_hilo", {hi, lo}, {m_hi, m_lo});

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 3'b000; d1 = 32'd7; d2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_hilo", {hi, lo}, 64'd0);
        check_eq("midrst_busy", {63'd0, busy}, 64'd0);
        check_eq("midrst_done", {63'd0, done}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (ML + 3) @(negedge clk);
        check_eq("midrst_idle", {63'd0, busy}, 64'd0);
        do_op("after_rst", 3'b000, 32'd7, 32'd9, 1'b0, 1'b0);
        check_eq("after_rst_val", {hi, lo}, 64'd63);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
